// File: rtl/dmem_access_unit.sv
// dmem_access_unit: data-memory responder for the MEM stage.
// Accepts one load/store per transaction, models WAIT_STATES wait cycles,
// applies RISC-V byte/half/word sizing with sign/zero extension and holds
// the pipeline through stall_o until done_o.
// Optional build macro: DMEM_MISALIGN_CHECK_EN -- when defined, misaligned
// half/word accesses complete with err_o instead of being force-aligned.
module dmem_access_unit #(
  parameter int DEPTH       = 256,
  parameter int WAIT_STATES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_read_i,
  input  logic        mem_write_i,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rdata_o,
  output logic        stall_o,
  output logic        done_o,
  output logic        err_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [3:0] CNT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_e;

  state_e        state_q;
  logic [3:0]    cnt_q;
  logic          is_write_q;
  logic [2:0]    funct3_q;
  logic [AW+1:0] addr_q;
  logic [31:0]   wdata_q;
  logic [31:0]   rdata_q;
  logic          done_q;
  logic          err_q;
  logic [31:0]   mem_q [DEPTH];

  logic          req_s;
  logic          sel_write_s;
  logic [2:0]    sel_f3_s;
  logic [AW+1:0] sel_addr_s;
  logic [1:0]    size_s;
  logic [1:0]    lane_s;
  logic          legal_s;
  logic          err_s;
  logic [AW-1:0] widx_s;
  logic [31:0]   word_s;
  logic [7:0]    byte_s;
  logic [15:0]   half_s;
  logic [31:0]   load_s;
  logic [3:0]    be_s;
  logic [31:0]   wlane_s;
  logic          enter_resp_s;
  logic          wr_en_s;
`ifdef DMEM_MISALIGN_CHECK_EN
  logic          misalign_s;
`endif

  assign req_s   = mem_read_i | mem_write_i;
  assign stall_o = ((state_q == S_IDLE) && req_s) || (state_q == S_WAIT);
  assign rdata_o = rdata_q;
  assign done_o  = done_q;
  assign err_o   = err_q;

  // Decode the live request while idle (zero-wait entry), else the latched one.
  always_comb begin
    if (state_q == S_IDLE) begin
      sel_write_s = mem_write_i;
      sel_f3_s    = funct3_i;
      sel_addr_s  = addr_i[AW+1:0];
    end else begin
      sel_write_s = is_write_q;
      sel_f3_s    = funct3_q;
      sel_addr_s  = addr_q;
    end
  end

  // Legality, alignment and byte-lane selection for the selected access.
  always_comb begin
    size_s = sel_f3_s[1:0];
    if (sel_write_s) begin
      legal_s = ~sel_f3_s[2] & (size_s != 2'b11);
    end else begin
      legal_s = (size_s != 2'b11) & ~(sel_f3_s[2] & (size_s == 2'b10));
    end
`ifdef DMEM_MISALIGN_CHECK_EN
    case (size_s)
      2'b01:   misalign_s = sel_addr_s[0];
      2'b10:   misalign_s = |sel_addr_s[1:0];
      default: misalign_s = 1'b0;
    endcase
    err_s  = ~legal_s | misalign_s;
    lane_s = sel_addr_s[1:0];
`else
    err_s = ~legal_s;
    case (size_s)
      2'b01:   lane_s = {sel_addr_s[1], 1'b0};
      2'b10:   lane_s = 2'b00;
      default: lane_s = sel_addr_s[1:0];
    endcase
`endif
  end

  // Read the addressed word and extend the selected byte/half to 32 bits.
  always_comb begin
    widx_s = sel_addr_s[AW+1:2];
    word_s = mem_q[widx_s];
    case (lane_s)
      2'd0:    byte_s = word_s[7:0];
      2'd1:    byte_s = word_s[15:8];
      2'd2:    byte_s = word_s[23:16];
      default: byte_s = word_s[31:24];
    endcase
    half_s = lane_s[1] ? word_s[31:16] : word_s[15:0];
    case (sel_f3_s)
      3'b000:  load_s = {{24{byte_s[7]}}, byte_s};
      3'b001:  load_s = {{16{half_s[15]}}, half_s};
      3'b010:  load_s = word_s;
      3'b100:  load_s = {24'd0, byte_s};
      3'b101:  load_s = {16'd0, half_s};
      default: load_s = 32'd0;
    endcase
  end

  // Byte enables and lane-replicated store data for the RAM write.
  always_comb begin
    case (size_s)
      2'b00: begin
        be_s    = 4'b0001 << lane_s;
        wlane_s = {4{wdata_q[7:0]}};
      end
      2'b01: begin
        be_s    = lane_s[1] ? 4'b1100 : 4'b0011;
        wlane_s = {2{wdata_q[15:0]}};
      end
      2'b10: begin
        be_s    = 4'b1111;
        wlane_s = wdata_q;
      end
      default: begin
        be_s    = 4'b0000;
        wlane_s = wdata_q;
      end
    endcase
  end

  // Detect the cycle whose closing edge moves the FSM into RESP.
  always_comb begin
    case (state_q)
      S_IDLE:  enter_resp_s = req_s && (WAIT_STATES == 0);
      S_WAIT:  enter_resp_s = (cnt_q == 4'd0);
      default: enter_resp_s = 1'b0;
    endcase
    wr_en_s = (state_q == S_RESP) && is_write_q && !err_q;
  end

  // Transaction FSM with registered completion, error and load result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= 4'd0;
      is_write_q <= 1'b0;
      funct3_q   <= 3'd0;
      addr_q     <= {(AW+2){1'b0}};
      wdata_q    <= 32'd0;
      rdata_q    <= 32'd0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      if (enter_resp_s) begin
        done_q <= 1'b1;
        err_q  <= err_s;
        if (err_s) begin
          rdata_q <= 32'd0;
        end else if (!sel_write_s) begin
          rdata_q <= load_s;
        end
      end
      case (state_q)
        S_IDLE: begin
          if (req_s) begin
            is_write_q <= mem_write_i;
            funct3_q   <= funct3_i;
            addr_q     <= addr_i[AW+1:0];
            wdata_q    <= wdata_i;
            cnt_q      <= CNT_LOAD;
            state_q    <= (WAIT_STATES > 0) ? S_WAIT : S_RESP;
          end
        end
        S_WAIT: begin
          if (cnt_q == 4'd0) begin
            state_q <= S_RESP;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        S_RESP:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Byte-enabled RAM write at the end of a successful store's RESP cycle.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      for (int i = 0; i < 4; i++) begin
        if (be_s[i]) begin
          mem_q[widx_s][8*i +: 8] <= wlane_s[8*i +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_dmem_access_unit.sv
// Self-checking bench for dmem_access_unit: directed vector table, reset and
// zero-wait sequences, then random traffic against a byte-array model.
module tb_dmem_access_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        a_rd, a_wr, b_rd, b_wr;
  logic [2:0]  a_f3, b_f3;
  logic [31:0] a_addr, a_wdata, a_rdata, b_addr, b_wdata, b_rdata;
  logic        a_stall, a_done, a_err, b_stall, b_done, b_err;

  dmem_access_unit #(.DEPTH(256), .WAIT_STATES(2)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .mem_read_i(a_rd), .mem_write_i(a_wr),
    .funct3_i(a_f3), .addr_i(a_addr), .wdata_i(a_wdata),
    .rdata_o(a_rdata), .stall_o(a_stall), .done_o(a_done), .err_o(a_err));

  dmem_access_unit #(.DEPTH(256), .WAIT_STATES(0)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .mem_read_i(b_rd), .mem_write_i(b_wr),
    .funct3_i(b_f3), .addr_i(b_addr), .wdata_i(b_wdata),
    .rdata_o(b_rdata), .stall_o(b_stall), .done_o(b_done), .err_o(b_err));

  int checks = 0;
  int failures = 0;
  bit sel_b = 1'b0;

  logic [31:0] c_rdata;
  logic        c_stall, c_done, c_err;
  assign c_rdata = sel_b ? b_rdata : a_rdata;
  assign c_stall = sel_b ? b_stall : a_stall;
  assign c_done  = sel_b ? b_done  : a_done;
  assign c_err   = sel_b ? b_err   : a_err;

  // Reference model: 1 KiB of bytes (DEPTH*4), little-endian.
  logic [7:0] mb [1024];

  typedef struct {
    bit          rd;
    bit          wr;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wd;
    bit          keep;
    logic [31:0] exp_rd;
    bit          exp_err;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(bit rd, bit wr, logic [2:0] f3, logic [31:0] addr,
                              logic [31:0] wd, bit keep, logic [31:0] exp_rd, bit exp_err);
    vec_t v;
    v.rd = rd; v.wr = wr; v.f3 = f3; v.addr = addr; v.wd = wd;
    v.keep = keep; v.exp_rd = exp_rd; v.exp_err = exp_err;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Apply one access to the byte model; rd_exp holds the last load result.
  task automatic model_op(input bit wr, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wd, inout logic [31:0] rd_exp, output bit err_exp);
    int size;
    int ea;
    bit legal;
    logic [31:0] v;
    size  = 1 << f3[1:0];
    legal = wr ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    ea    = int'(addr[9:0]);
`ifdef DMEM_MISALIGN_CHECK_EN
    err_exp = !legal || ((ea % size) != 0);
`else
    err_exp = !legal;
    ea = ea - (ea % size);
`endif
    if (err_exp) begin
      rd_exp = 32'd0;
    end else if (wr) begin
      for (int i = 0; i < size; i++) mb[ea + i] = wd[8*i +: 8];
    end else begin
      v = 32'd0;
      for (int i = 0; i < size; i++) v = v | (32'(mb[ea + i]) << (8 * i));
      if (!f3[2] && size < 4 && v[8*size - 1]) v = v | (32'hFFFF_FFFF << (8 * size));
      rd_exp = v;
    end
  endtask

  task automatic drive(input bit rd, input bit wr, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wd);
    if (sel_b) begin
      b_rd = rd; b_wr = wr; b_f3 = f3; b_addr = addr; b_wdata = wd;
    end else begin
      a_rd = rd; a_wr = wr; a_f3 = f3; a_addr = addr; a_wdata = wd;
    end
  endtask

  // One full transaction on the selected DUT with latency/stall/pulse checks.
  task automatic run_op(input bit rd, input bit wr, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd, input int ws,
                        output logic [31:0] got_rdata, output logic got_err);
    int cyc;
    int stalls;
    bit seen;
    @(negedge clk);
    drive(rd, wr, f3, addr, wd);
    #1;
    stalls = c_stall ? 1 : 0;
    cyc = 0;
    seen = 1'b0;
    while (!seen && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) drive(1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
      #1;
      if (c_done) seen = 1'b1;
      else if (c_stall) stalls++;
    end
    check("done_seen", 32'(seen), 32'd1);
    check("latency", 32'(cyc), 32'(ws + 1));
    check("stall_cycles", 32'(stalls), 32'(ws + 1));
    check("stall_in_resp", 32'(c_stall), 32'd0);
    got_rdata = c_rdata;
    got_err   = c_err;
    @(negedge clk);
    #1;
    check("done_err_one_cycle", {30'd0, c_done, c_err}, 32'd0);
  endtask

  initial begin
    logic [31:0] gr, model_rd, last_rd, r, addr;
    logic        ge;
    bit          me, rd, wr, seen_done;
    logic [2:0]  f3;

    a_rd = 1'b0; a_wr = 1'b0; a_f3 = 3'd0; a_addr = 32'd0; a_wdata = 32'd0;
    b_rd = 1'b0; b_wr = 1'b0; b_f3 = 3'd0; b_addr = 32'd0; b_wdata = 32'd0;
    model_rd = 32'd0;
    for (int i = 0; i < 1024; i++) mb[i] = 8'd0;

    tbl.push_back(mk(0, 1, 3'b010, 32'h10, 32'hDEADBEEF, 1, 32'd0, 0));
    tbl.push_back(mk(1, 0, 3'b010, 32'h10, 32'd0, 0, 32'hDEADBEEF, 0));
    tbl.push_back(mk(0, 1, 3'b010, 32'h20, 32'h80FF7F01, 1, 32'd0, 0));
    tbl.push_back(mk(1, 0, 3'b000, 32'h22, 32'd0, 0, 32'hFFFFFFFF, 0));
    tbl.push_back(mk(1, 0, 3'b100, 32'h23, 32'd0, 0, 32'h00000080, 0));
    tbl.push_back(mk(1, 0, 3'b001, 32'h20, 32'd0, 0, 32'h00007F01, 0));
    tbl.push_back(mk(1, 0, 3'b101, 32'h22, 32'd0, 0, 32'h000080FF, 0));
    tbl.push_back(mk(0, 1, 3'b010, 32'h30, 32'h11223344, 1, 32'd0, 0));
    tbl.push_back(mk(0, 1, 3'b000, 32'h31, 32'h123456AA, 1, 32'd0, 0));
    tbl.push_back(mk(1, 0, 3'b010, 32'h30, 32'd0, 0, 32'h1122AA44, 0));
    tbl.push_back(mk(0, 1, 3'b001, 32'h32, 32'hCAFEBEEF, 1, 32'd0, 0));
    tbl.push_back(mk(1, 0, 3'b010, 32'h30, 32'd0, 0, 32'hBEEFAA44, 0));
    tbl.push_back(mk(1, 0, 3'b011, 32'h30, 32'd0, 0, 32'h00000000, 1));
    tbl.push_back(mk(1, 0, 3'b010, 32'h30, 32'd0, 0, 32'hBEEFAA44, 0));
    tbl.push_back(mk(1, 1, 3'b010, 32'h50, 32'h5A5A0001, 1, 32'd0, 0));
    tbl.push_back(mk(1, 0, 3'b010, 32'h50, 32'd0, 0, 32'h5A5A0001, 0));
    tbl.push_back(mk(0, 1, 3'b011, 32'h50, 32'hFFFFFFFF, 0, 32'h00000000, 1));
    tbl.push_back(mk(1, 0, 3'b010, 32'h50, 32'd0, 0, 32'h5A5A0001, 0));
    tbl.push_back(mk(0, 1, 3'b010, 32'h40, 32'hCAFEF00D, 1, 32'd0, 0));
`ifdef DMEM_MISALIGN_CHECK_EN
    tbl.push_back(mk(1, 0, 3'b010, 32'h41, 32'd0, 0, 32'h00000000, 1));
`else
    tbl.push_back(mk(1, 0, 3'b010, 32'h41, 32'd0, 0, 32'hCAFEF00D, 0));
`endif
    tbl.push_back(mk(1, 0, 3'b010, 32'h410, 32'd0, 0, 32'hDEADBEEF, 0));
    tbl.push_back(mk(1, 0, 3'b010, 32'hFFFF0410, 32'd0, 0, 32'hDEADBEEF, 0));
`ifdef DMEM_MISALIGN_CHECK_EN
    tbl.push_back(mk(0, 1, 3'b001, 32'h43, 32'h00001234, 0, 32'h00000000, 1));
    tbl.push_back(mk(1, 0, 3'b010, 32'h40, 32'd0, 0, 32'hCAFEF00D, 0));
`else
    tbl.push_back(mk(0, 1, 3'b001, 32'h43, 32'h00001234, 1, 32'd0, 0));
    tbl.push_back(mk(1, 0, 3'b010, 32'h40, 32'd0, 0, 32'h1234F00D, 0));
`endif
    tbl.push_back(mk(1, 0, 3'b100, 32'h41, 32'd0, 0, 32'h000000F0, 0));

    // Reset state.
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_rdata", a_rdata, 32'd0);
    check("reset_flags", {29'd0, a_stall, a_done, a_err}, 32'd0);
    rst_n = 1'b1;

    // Directed table on the two-wait-state DUT.
    last_rd = 32'd0;
    foreach (tbl[k]) begin
      run_op(tbl[k].rd, tbl[k].wr, tbl[k].f3, tbl[k].addr, tbl[k].wd, 2, gr, ge);
      model_op(tbl[k].wr, tbl[k].f3, tbl[k].addr, tbl[k].wd, model_rd, me);
      if (!tbl[k].keep) last_rd = tbl[k].exp_rd;
      check($sformatf("tbl%0d_rdata", k), gr, last_rd);
      check($sformatf("tbl%0d_err", k), 32'(ge), 32'(tbl[k].exp_err));
    end

    // Reset during WAIT of a store: abandoned, no done, RAM unchanged.
    @(negedge clk);
    drive(1'b0, 1'b1, 3'b010, 32'h40, 32'h12345678);
    @(negedge clk);
    drive(1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
    #1;
    check("rst_mid_wait_stall", 32'(a_stall), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_async_flags", {29'd0, a_stall, a_done, a_err}, 32'd0);
    check("rst_async_rdata", a_rdata, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen_done = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (a_done) seen_done = 1'b1;
    end
    check("rst_no_done", 32'(seen_done), 32'd0);
    model_rd = 32'd0;
    run_op(1'b1, 1'b0, 3'b010, 32'h40, 32'd0, 2, gr, ge);
    model_op(1'b0, 3'b010, 32'h40, 32'd0, model_rd, me);
    check("rst_prior_contents", gr, model_rd);

    // Zero-wait-state instance.
    sel_b = 1'b1;
    run_op(1'b0, 1'b1, 3'b010, 32'h88, 32'h0BADC0DE, 0, gr, ge);
    check("ws0_store_err", 32'(ge), 32'd0);
    run_op(1'b1, 1'b0, 3'b010, 32'h88, 32'd0, 0, gr, ge);
    check("ws0_lw", gr, 32'h0BADC0DE);
    run_op(1'b1, 1'b0, 3'b100, 32'h8B, 32'd0, 0, gr, ge);
    check("ws0_lbu", gr, 32'h0000000B);
    sel_b = 1'b0;

    // Random traffic on the first 32 words (with random aliasing bits).
    for (int i = 0; i < 32; i++) begin
      r = $urandom;
      run_op(1'b0, 1'b1, 3'b010, 32'(i * 4), r, 2, gr, ge);
      model_op(1'b1, 3'b010, 32'(i * 4), r, model_rd, me);
    end
    for (int n = 0; n < 150; n++) begin
      rd = 1'($urandom_range(0, 1));
      wr = 1'($urandom_range(0, 1));
      if (!rd && !wr) rd = 1'b1;
      f3 = 3'($urandom_range(0, 7));
      r = $urandom;
      addr = (r & 32'hFFFF_FC00) | 32'($urandom_range(0, 127));
      r = $urandom;
      run_op(rd, wr, f3, addr, r, 2, gr, ge);
      model_op(wr, f3, addr, r, model_rd, me);
      check($sformatf("rand%0d_rdata f3=%0d a=%h", n, f3, addr), gr, model_rd);
      check($sformatf("rand%0d_err", n), 32'(ge), 32'(me));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dmem_access_unit.md
Name: dmem_access_unit

Overview:
Data-memory responder: the memory-side end of the MemRead/MemWrite control signals produced by the decode controller. It accepts one load or store per transaction from the EX/MEM stage and applies RISC-V byte, halfword and word sizing with sign or zero extension. It models a configurable number of wait states and holds the pipeline with stall_o until the access completes. It contains the data RAM (word-organised, byte-enabled) and feeds load data to the MEM/WB write-back path.

Parameters:
DEPTH, 256, number of 32-bit words in the data RAM; power of two.
WAIT_STATES, 2, extra cycles between request acceptance and completion (0..15).

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  reset, asynchronous, active-low
mem_read_i  input  1  load request (MemRead)
mem_write_i  input  1  store request (MemWrite)
funct3_i  input  3  access size/sign from instruction funct3
addr_i  input  32  byte address (ALU result)
wdata_i  input  32  store data (rs2)
rdata_o  output  32  load result, extended to 32 bits
stall_o  output  1  pipeline hold request
done_o  output  1  one-cycle completion pulse
err_o  output  1  one-cycle error pulse, coincident with done_o

Behaviour:
- Interface fixed: one clock clk; reset rst_n is asynchronous, active-low.
- Reset: state IDLE; rdata_o=0, stall_o=0, done_o=0, err_o=0; latched request cleared; RAM contents not reset.
- FSM states IDLE, WAIT, RESP.
- IDLE: if mem_write_i or mem_read_i is high, latch addr_i, wdata_i, funct3_i and the kind (write if mem_write_i, else read). Next state is WAIT if WAIT_STATES>0, else RESP. stall_o is high combinationally in this acceptance cycle.
- If mem_read_i and mem_write_i are both high: treated as a store; the read is ignored.
- WAIT: a counter loaded with WAIT_STATES-1 decrements each cycle; the state moves to RESP after the count reaches 0. stall_o=1 throughout.
- RESP: done_o=1 and stall_o=0. Stores write the RAM at the end of this cycle. rdata_o is registered on entry to RESP and holds until the next completed load; stores and errors leave it unchanged except as stated below. The next state is always IDLE; requests presented during RESP are not accepted.
- Latency: done_o asserts exactly WAIT_STATES+1 cycles after the acceptance edge. stall_o is high for WAIT_STATES+1 consecutive cycles per access.
- Word index is addr[log2(DEPTH)+1:2]; higher bits are ignored, so addresses wrap modulo DEPTH*4.
- Loads: 000 lb (sign-extend byte at addr[1:0]), 001 lh (sign-extend half at addr[1]), 010 lw, 100 lbu, 101 lhu (zero-extend).
- Stores: 000 sb, 001 sh, 010 sw. Only the addressed byte lanes are written; the remaining bytes of the word are preserved.
- Illegal funct3 (load 011/110/111, store 011..111): err_o=1 with done_o, no RAM write, rdata_o=0.
- Reset asserted mid-operation (WAIT or RESP): return to IDLE immediately; a pending store is abandoned with no RAM write; no done_o is produced.

Optional Feature:
DMEM_MISALIGN_CHECK_EN
- Defined: misaligned access (lh/lhu/sh with addr[0]=1; lw/sw with addr[1:0]!=0) completes with normal latency, err_o=1, no RAM write, rdata_o=0.
- Undefined: low address bits are forced aligned (addr[0] cleared for halves, addr[1:0] cleared for words). err_o fires only for illegal funct3.

Test Plan:
- WAIT_STATES=2: sw 0xDEADBEEF @0x10 accepted cycle 0 -> stall_o=1 cycles 0-2, done_o=1 cycle 3; following lw @0x10 -> rdata_o=0xDEADBEEF with done_o.
- Word @0x20 = 0x80FF7F01: lb @0x22 -> 0xFFFFFFFF; lbu @0x23 -> 0x00000080; lh @0x20 -> 0x00007F01; lhu @0x22 -> 0x000080FF.
- Word @0x30 = 0x11223344: sb 0xAA @0x31 -> lw @0x30 reads 0x1122AA44; sh 0xBEEF @0x32 -> lw reads 0xBEEFAA44.
- Illegal load funct3=011 -> done_o and err_o pulse together, rdata_o=0, RAM unchanged. mem_read_i and mem_write_i both high -> store performed.
- Reset pulse during WAIT of sw 0x12345678 @0x40 -> no done_o; after release, lw @0x40 returns the prior contents. Separately, with WAIT_STATES=0: done_o is exactly 1 cycle after acceptance.
- With DMEM_MISALIGN_CHECK_EN: lw @0x41 -> err_o=1, rdata_o=0. Without it: lw @0x41 returns word @0x40, err_o=0. Address DEPTH*4+0x10 aliases to 0x10.
